// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-add multiplier. An operand pair is accepted in IDLE, one
// multiplier bit is consumed per clock in BUSY (exactly WIDTH cycles), and
// the full 2*WIDTH-bit product is presented in DONE until the consumer
// takes it.
//
// Optional feature macro: SEQ_MULT_SIGNED_EN
//   When defined, adds the signed_op input. When signed_op is 1 at the
//   accept edge, a and b are treated as two's complement. Latency and
//   handshake are identical in both modes.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : synchronous, active-high reset
//   signed_op  : (SEQ_MULT_SIGNED_EN only) 1 = signed operation
//   in_valid   : operands a/b are presented
//   in_ready   : block can accept operands (IDLE)
//   a, b       : multiplicand and multiplier, WIDTH bits
//   out_valid  : product holds a valid result (DONE)
//   out_ready  : consumer accepts the result
//   product    : registered result, 2*WIDTH bits
//   busy       : high while the shift-add iteration runs (BUSY)
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]    mcand;      // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;     // multiplier, shifted right each step
    logic [PW-1:0]    acc;        // partial product
    logic [CW-1:0]    cnt;        // index of the multiplier bit in mplier[0]
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    step_term;
    logic [PW-1:0]    acc_next;
    logic             op_signed;
    logic             last_step;
    logic             accept;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q;

    // Signedness is captured with the operands so later changes of
    // signed_op cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= signed_op;
        end
    end

    assign op_signed = sign_q;
    assign a_ext     = (signed_op && a[WIDTH-1]) ? {{WIDTH{1'b1}}, a}
                                                 : {{WIDTH{1'b0}}, a};
`else
    assign op_signed = 1'b0;
    assign a_ext     = {{WIDTH{1'b0}}, a};
`endif

    // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement,
    // so for a signed operation the last step subtracts instead of adding.
    // With the multiplicand sign-extended to 2*WIDTH bits this yields the
    // exact signed product modulo 2^(2*WIDTH) in the same WIDTH steps.
    always_comb begin
        step_term = mplier[0] ? mcand : '0;
        acc_next  = (last_step && op_signed) ? (acc - step_term)
                                             : (acc + step_term);
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. product is written only on the step that enters DONE, so it
    // keeps its last value through IDLE and BUSY.
    // NOTE: the datapath registers are reset as well, because the visible
    // product must read 0 after reset rather than a stale result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= a_ext;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                product <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Self-checking bench for seq_multiplier. Two instances: WIDTH=8 for
// directed, randomized, backpressure, reset and (when SEQ_MULT_SIGNED_EN is
// defined) signed cases; WIDTH=4 for an exhaustive back-to-back sweep.
// Expected products come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic        rst8;
    logic        iv8;
    logic        ir8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ov8;
    logic        or8;
    logic [15:0] p8;
    logic        busy8;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sg8;
`endif

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (sg8),
`endif
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .product   (p8),
        .busy      (busy8)
    );

    // WIDTH = 4 instance
    logic        rst4;
    logic        iv4;
    logic        ir4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        ov4;
    logic        or4;
    logic [7:0]  p4;
    logic        busy4;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sg4;
`endif

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (sg4),
`endif
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .out_valid (ov4),
        .out_ready (or4),
        .product   (p4),
        .busy      (busy4)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer product of the operands, truncated to 2*w bits.
    function automatic longint ref_mul(input longint a, input longint b,
                                       input int w, input bit sg);
        longint sa = a;
        longint sb = b;
        longint half = longint'(1) << (w - 1);
        longint mask = (longint'(1) << (2 * w)) - 1;
        if (sg && sa >= half) sa = sa - (half << 1);
        if (sg && sb >= half) sb = sb - (half << 1);
        return (sa * sb) & mask;
    endfunction

    // One WIDTH=8 transaction with 'bp' cycles of backpressure in DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input bit sg, input int bp);
        longint exp = ref_mul(longint'(a), longint'(b), 8, sg);
        int     lat = 0;
        @(negedge clk);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        or8 = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sg8 = sg;
`endif
        check("in_ready_idle", ir8, 1);
        @(posedge clk); #1;
        check("busy_after_accept", busy8, 1);
        // Scramble inputs while busy; they must not affect the result.
        while (!ov8 && lat < 20) begin
            iv8 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            sg8 = 1'($urandom);
`endif
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 8);
        check("product", p8, exp);
        for (int k = 0; k < bp; k++) begin
            iv8 = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", ov8, 1);
            check("hold_product", p8, exp);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        or8 = 1'b0;
        check("idle_out_valid", ov8, 0);
        check("idle_in_ready", ir8, 1);
        check("idle_product_kept", p8, exp);
        @(posedge clk); #1;
        check("single_result", {ov8, busy8}, 2'b00);
    endtask

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        rst4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sg8 = 1'b0;
        sg4 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0;
        rst4 = 1'b0;
        check("rst_in_ready", ir8, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_busy", busy8, 0);
        check("rst_product", p8, 0);

        // Directed cases
        op8(8'd14,  8'd15,  1'b0, 0);
        op8(8'd255, 8'd255, 1'b0, 0);
        op8(8'd0,   8'd200, 1'b0, 0);
        op8(8'd173, 8'd91,  1'b0, 5);

`ifdef SEQ_MULT_SIGNED_EN
        op8(8'h80, 8'h80, 1'b1, 0);
        op8(8'hFD, 8'h07, 1'b1, 0);
        op8(8'hFD, 8'h07, 1'b0, 0);
`endif

        // Randomized
        for (int i = 0; i < 40; i++) begin
            bit sg = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sg = 1'($urandom);
`endif
            op8(8'($urandom), 8'($urandom), sg, int'($urandom_range(0, 3)));
        end

        // Reset during the 4th BUSY cycle
        begin
            bit seen_valid = 1'b0;
            @(negedge clk);
            a8 = 8'd99; b8 = 8'd77; iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("pre_rst_busy", busy8, 1);
            rst8 = 1'b1;
            @(posedge clk); #1;
            rst8 = 1'b0;
            check("midrst_in_ready", ir8, 1);
            check("midrst_busy", busy8, 0);
            check("midrst_product", p8, 0);
            or8 = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (ov8) seen_valid = 1'b1;
            end
            or8 = 1'b0;
            check("midrst_no_output", seen_valid, 0);
        end

        // WIDTH=4 exhaustive, back-to-back with out_ready tied high
        begin
            int prev_t = 0;
            or4 = 1'b1;
            iv4 = 1'b1;
            for (int i = 0; i < 256; i++) begin
                int t;
                int guard = 0;
                logic [3:0] av = 4'(i >> 4);
                logic [3:0] bv = 4'(i);
                a4 = av;
                b4 = bv;
                while (!ir4 && guard < 20) begin
                    @(posedge clk); #1;
                    guard++;
                end
                if (guard >= 20) check("w4_ready_timeout", 1, 0);
                @(posedge clk);
                t = cyc;
                #1;
                if (i > 0) check("w4_interval", t - prev_t, 6);
                prev_t = t;
                guard = 0;
                while (!ov4 && guard < 20) begin
                    @(posedge clk); #1;
                    guard++;
                end
                check("w4_product", p4, ref_mul(longint'(av), longint'(bv), 4, 1'b0));
            end
            iv4 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
